// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encodings and the
//   legal range of the WIDTH parameter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sa_state_e;

  // Legal range of the WIDTH parameter. The bit counter is sized with $clog2,
  // so WIDTH=1 would give a zero-width counter.
  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage : serial_adder_pkg

// File: rtl/gate_lib.sv
// gate_lib
//   Two-input gate library. The only primitive is nand2; and2, or2 and xor2
//   are built from nand2 instances only.
//   Ports (all gates): a, b inputs; y output.

module nand2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule : nand2

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n_ab;

  nand2 u_n0 (.a(a),    .b(b),    .y(n_ab));
  nand2 u_n1 (.a(n_ab), .b(n_ab), .y(y));
endmodule : and2

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n_a;
  logic n_b;

  // De Morgan: a | b = ~(~a & ~b)
  nand2 u_n0 (.a(a),   .b(a),   .y(n_a));
  nand2 u_n1 (.a(b),   .b(b),   .y(n_b));
  nand2 u_n2 (.a(n_a), .b(n_b), .y(y));
endmodule : or2

module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n_ab;
  logic t_a;
  logic t_b;

  // Classic four-NAND XOR.
  nand2 u_n0 (.a(a),   .b(b),    .y(n_ab));
  nand2 u_n1 (.a(a),   .b(n_ab), .y(t_a));
  nand2 u_n2 (.a(b),   .b(n_ab), .y(t_b));
  nand2 u_n3 (.a(t_a), .b(t_b),  .y(y));
endmodule : xor2

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   One-bit full adder assembled structurally from the gate library.
//   Ports: x, y, ci - addend bits and carry in
//          s        - sum bit      (x ^ y ^ ci)
//          co       - carry out    (x & y) | (ci & (x ^ y))
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;   // propagate
  logic g;   // generate
  logic t;   // carry propagated from ci

  xor2 u_xor_p  (.a(x),  .b(y),  .y(p));
  xor2 u_xor_s  (.a(p),  .b(ci), .y(s));
  and2 u_and_g  (.a(x),  .b(y),  .y(g));
  and2 u_and_t  (.a(ci), .b(p),  .y(t));
  or2  u_or_co  (.a(g),  .b(t),  .y(co));
endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder computing a + b + cin, LSB first, one bit per
//   clock through a single structural full adder.
//   Ports: clk, rst (async, active-high)
//          start, a, b, cin - request and operands, captured on acceptance
//          busy             - bits being processed (WIDTH cycles)
//          done             - one-cycle pulse, sum/cout valid
//          sum, cout        - result, held after done
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; sum/cout hold the last result
//   RUN     | one result bit per cycle, cnt counts processed bits
//   DONE    | done pulse; start here restarts directly into RUN
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8  // legal range WIDTH_MIN..WIDTH_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_c;

  full_adder u_fa (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          opa_d   = a;
          opb_d   = b;
          c_d     = cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        res_d = {fa_s, res_q[WIDTH-1:1]};
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        c_d   = fa_c;
        if (cnt_q == CNT_LAST) begin
          // Counter parks at WIDTH-1 rather than incrementing, so it never
          // wraps when WIDTH is a power of two.
          state_d = ST_DONE;
          cout_d  = fa_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  // Decoded straight from the state register: glitch-free, zero in reset,
  // and mutually exclusive by construction.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = res_q;
  assign cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: on every done pulse, pop the oldest expected result and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_sum", 32'(sum), 32'(e.s));
          chk("done_cout", 32'(cout), 32'(e.co));
        end
      end
    end
  end

  // Single operation with a one-cycle start pulse; checks busy length,
  // done arrival and that the result holds in the following IDLE cycle.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic [W-1:0] es, input logic eco);
    int bc;
    bit seen;
    exp_t e;
    e.s  = es;
    e.co = eco;
    exp_q.push_back(e);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '1; b = '1; cin = 1'b1;   // operands must already be captured
    bc = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_cycles", 32'(bc), 32'(W));
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("hold_sum", 32'(sum), 32'(es));
    chk("hold_cout", 32'(cout), 32'(eco));
  endtask

  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1;
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;
    exp_t e;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);

    // Reset mid-run: cout is 1 from the overflow case and must clear.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (WIDTH_WAIT()) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

    // Back-to-back: start held high, operands changed during the first run.
    e.s = 8'h02; e.co = 1'b0; exp_q.push_back(e);
    e.s = 8'h30; e.co = 1'b0; exp_q.push_back(e);
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    wait_done(cyc, seen);
    chk("b2b_first_done", 32'(seen), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    wait_done(cyc, seen);
    chk("b2b_second_done", 32'(seen), 32'd1);
    chk("b2b_gap", 32'(cyc + 1), 32'd9);
    repeat (3) @(negedge clk);
    chk("b2b_back_idle", 32'({busy, done}), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  function automatic int WIDTH_WAIT();
    return W + 2;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder
